traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive observer for the 2-bit `light` bus driven by `traffic_light`: 00 Red, 01 Green, 10 Yellow.
- Runs in the same clock domain as the controller.
- Tracks the current phase and measures dwell time in each phase.
- Checks the Red→Green→Yellow→Red order and counts completed cycles.
- Raises error pulses and a sticky error flag.
- Used as an in-design health checker and as a scoreboard helper in controller benches.

## Interface
- `CNT_W`, 8: dwell counter width; the counter saturates at 2^CNT_W−1.
- `RED_MIN`, 4: minimum legal Red dwell, in cycles.
- `RED_MAX`, 8: maximum legal Red dwell, in cycles.
- `GREEN_MIN`, 4: minimum legal Green dwell, in cycles.
- `GREEN_MAX`, 8: maximum legal Green dwell, in cycles.
- `YELLOW_MIN`, 2: minimum legal Yellow dwell, in cycles.
- `YELLOW_MAX`, 3: maximum legal Yellow dwell, in cycles.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `light`  in  2  observed light code; 11 is illegal.
- `err_clr`  in  1  synchronous clear of `err_sticky`.
- `cur_phase`  out  2  last accepted legal code; 11 = unsynchronised.
- `dwell`  out  CNT_W  cycles the current phase has been held, including the current cycle.
- `cycle_count`  out  16  completed Y→R transitions; wraps.
- `seq_err`  out  1  one-cycle pulse on an illegal transition.
- `illegal_code`  out  1  one-cycle pulse when `light`=11 is sampled.
- `dwell_err`  out  1  one-cycle pulse on a dwell-bound violation.
- `err_sticky`  out  1  OR of all error pulses; held until cleared.

## Operation
- **States:**
  - SYNC: no phase known.
  - TRACK: phase known; the `first` bit marks a partial phase.
- **Reset values:**
  - State SYNC; `cur_phase`=11.
  - `dwell`, `cycle_count`, all pulses and `err_sticky` = 0.
- **SYNC:**
  - Sampled legal code → TRACK with `cur_phase`=code, `dwell`=1, `first`=1.
  - Sampled 11 → `illegal_code` pulse; remain in SYNC.
- **TRACK, same code:** `dwell`+1, saturating.
- **TRACK, legal transition (R→G, G→Y, Y→R):**
  - `cur_phase`=new code, `dwell`=1, `first`=0.
  - If `first`=0 and the completed dwell < MIN of the old phase → `dwell_err`.
  - Y→R increments `cycle_count`.
- **TRACK, illegal transition** (any other change between legal codes):
  - `seq_err` pulse.
  - Resynchronise: `cur_phase`=new code, `dwell`=1, `first`=1.
  - No min check on the aborted phase.
- **TRACK, sampled 11:** `illegal_code` pulse; → SYNC; `cur_phase`=11; `dwell`=0.
- **Max check:**
  - `dwell_err` pulses on the edge where `dwell` would become MAX+1 of the current phase.
  - Fires exactly once per phase.
  - Applies to first phases too.
- **Simultaneous events:**
  - A transition's min violation and `seq_err` cannot coincide, because an illegal transition skips the min check.
  - Saturation never re-triggers the max pulse.
- **`err_sticky`:**
  - Set by any pulse.
  - Cleared on the edge where `err_clr`=1.
  - If set and clear occur in the same cycle, set wins.

## Timing
- `light` is sampled at rising edge k, with no input synchroniser.
- All outputs are registered and update at edge k.
- Each pulse is high for exactly one cycle, from edge k to edge k+1.
- Latency from a sampled change to the flag: 0 extra cycles beyond the sampling edge.
- Back-to-back violations on consecutive edges give back-to-back pulses.
- Reset asserted mid-phase forces all reset values immediately, without waiting for a clock edge.
- After reset deasserts, the first rising edge samples from SYNC.

## Configuration
- Macro: `TL_MON_DWELL_CHECK_EN`.
- **Defined:** min/max dwell checks active; `dwell_err` behaves as above.
- **Undefined:**
  - Dwell-check logic is removed.
  - `dwell_err` is tied to 0.
  - The `dwell` counter and `cur_phase` still operate.

## Test plan
All scenarios use default parameters and start from reset.
- **Legal cycle:** R×5, G×5, Y×2, then R → no pulses; `cycle_count`=1 at the edge sampling R; `dwell`=1 there.
- **Illegal transition:** R×5, G×5, then R → `seq_err` pulses one cycle; `err_sticky`=1; `cur_phase`=00; `cycle_count`=0.
- **Illegal code:** R×5, then one sample of 11, then G → `illegal_code` pulse and `cur_phase`=11 at the 11 sample; G is accepted as a first phase with no `seq_err`.
- **Max violation:** R×5, then G held 12 cycles → `dwell_err` pulses once, at the 9th G sample. With the macro undefined there is no pulse.
- **Min violation:** R×5, G×5, Y×1, then R → `dwell_err` at the R sample; `cycle_count`=1; `err_sticky`=1. Then `err_clr`=1 for one cycle → `err_sticky`=0.
- **Reset mid-phase:** assert `reset` asynchronously during G → all outputs at reset values immediately. After release, Y is accepted as a first phase with no `seq_err`.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Observation bundle between a traffic_light controller's light bus and its monitor.
// master = whoever drives light/err_clr; slave = the monitor producing the status outputs.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       light;
    logic             err_clr;
    logic [1:0]       cur_phase;
    logic [CNT_W-1:0] dwell;
    logic [15:0]      cycle_count;
    logic             seq_err;
    logic             illegal_code;
    logic             dwell_err;
    logic             err_sticky;
    logic [1:0]       dbg_state;   // {tracking, first}

    modport master (
        output light, err_clr,
        input  cur_phase, dwell, cycle_count, seq_err, illegal_code,
               dwell_err, err_sticky, dbg_state
    );

    modport slave (
        input  light, err_clr,
        output cur_phase, dwell, cycle_count, seq_err, illegal_code,
               dwell_err, err_sticky, dbg_state
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive Red->Green->Yellow order and dwell-time checker for the traffic_light bus.
// Dwell min/max checking is compiled in only when TL_MON_DWELL_CHECK_EN is defined.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int RED_MIN    = 4,
    parameter int RED_MAX    = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    traffic_light_monitor_if.slave mon
);

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [1:0]       CODE_RED    = 2'b00;
    localparam logic [1:0]       CODE_GREEN  = 2'b01;
    localparam logic [1:0]       CODE_YELLOW = 2'b10;
    localparam logic [1:0]       CODE_ILL    = 2'b11;
    localparam logic [CNT_W-1:0] DWELL_SAT   = '1;
    localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             first_q, first_d;
    logic [15:0]      cycle_q, cycle_d;
    logic             seq_err_q, seq_err_d;
    logic             ill_q, ill_d;
    logic             dwell_err_q, dwell_err_d;
    logic             sticky_q, sticky_d;
    logic             legal_step;

    assign legal_step = ((phase_q == CODE_RED)    && (mon.light == CODE_GREEN))  ||
                        ((phase_q == CODE_GREEN)  && (mon.light == CODE_YELLOW)) ||
                        ((phase_q == CODE_YELLOW) && (mon.light == CODE_RED));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dwell_d   = dwell_q;
        first_d   = first_q;
        cycle_d   = cycle_q;
        seq_err_d = 1'b0;
        ill_d     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (mon.light == CODE_ILL) begin
                    ill_d = 1'b1;
                end else begin
                    state_d = ST_TRACK;
                    phase_d = mon.light;
                    dwell_d = DWELL_ONE;
                    first_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (mon.light == CODE_ILL) begin
                    ill_d   = 1'b1;
                    state_d = ST_SYNC;
                    phase_d = CODE_ILL;
                    dwell_d = '0;
                    first_d = 1'b0;
                end else if (mon.light == phase_q) begin
                    if (dwell_q != DWELL_SAT) dwell_d = dwell_q + DWELL_ONE;
                end else if (legal_step) begin
                    phase_d = mon.light;
                    dwell_d = DWELL_ONE;
                    first_d = 1'b0;
                    if (phase_q == CODE_YELLOW) cycle_d = cycle_q + 16'd1;
                end else begin
                    // Out-of-order change: restart on the new code as a partial phase.
                    seq_err_d = 1'b1;
                    phase_d   = mon.light;
                    dwell_d   = DWELL_ONE;
                    first_d   = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

`ifdef TL_MON_DWELL_CHECK_EN
    logic        max_done_q, max_done_d;
    logic [31:0] cur_min, cur_max;
    logic [31:0] dwell_ext;

    assign dwell_ext = 32'(dwell_q);

    always_comb begin
        cur_min = 32'(RED_MIN);
        cur_max = 32'(RED_MAX);
        case (phase_q)
            CODE_GREEN: begin
                cur_min = 32'(GREEN_MIN);
                cur_max = 32'(GREEN_MAX);
            end
            CODE_YELLOW: begin
                cur_min = 32'(YELLOW_MIN);
                cur_max = 32'(YELLOW_MAX);
            end
            default: begin
                cur_min = 32'(RED_MIN);
                cur_max = 32'(RED_MAX);
            end
        endcase
    end

    // max_done_q keeps a saturated counter from pulsing again within one phase.
    always_comb begin
        dwell_err_d = 1'b0;
        max_done_d  = 1'b0;
        if ((state_q == ST_TRACK) && (mon.light != CODE_ILL)) begin
            if (mon.light == phase_q) begin
                max_done_d = max_done_q;
                if (!max_done_q && (dwell_ext == cur_max)) begin
                    dwell_err_d = 1'b1;
                    max_done_d  = 1'b1;
                end
            end else if (legal_step && !first_q && (dwell_ext < cur_min)) begin
                dwell_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) max_done_q <= 1'b0;
        else       max_done_q <= max_done_d;
    end
`else
    assign dwell_err_d = 1'b0;
`endif

    assign sticky_d = seq_err_d | ill_d | dwell_err_d | (sticky_q & ~mon.err_clr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            phase_q     <= CODE_ILL;
            dwell_q     <= '0;
            first_q     <= 1'b0;
            cycle_q     <= '0;
            seq_err_q   <= 1'b0;
            ill_q       <= 1'b0;
            dwell_err_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dwell_q     <= dwell_d;
            first_q     <= first_d;
            cycle_q     <= cycle_d;
            seq_err_q   <= seq_err_d;
            ill_q       <= ill_d;
            dwell_err_q <= dwell_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign mon.cur_phase    = phase_q;
    assign mon.dwell        = dwell_q;
    assign mon.cycle_count  = cycle_q;
    assign mon.seq_err      = seq_err_q;
    assign mon.illegal_code = ill_q;
    assign mon.dwell_err    = dwell_err_q;
    assign mon.err_sticky   = sticky_q;
    assign mon.dbg_state    = {state_q == ST_TRACK, first_q};

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; dwell expectations follow TL_MON_DWELL_CHECK_EN.
module tb_traffic_light_monitor;
    localparam int         CNT_W = 8;
    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] X = 2'b11;
`ifdef TL_MON_DWELL_CHECK_EN
    localparam logic DEN = 1'b1;
`else
    localparam logic DEN = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    traffic_light_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    traffic_light_monitor #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .mon   (mon_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        reset         = 1'b1;
        mon_if.light  = R;
        mon_if.err_clr = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input logic [1:0] code);
        mon_if.light = code;
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) step(code);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mon_if.light = G;
        mon_if.err_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (mon_if.cur_phase !== X || mon_if.dwell !== 8'd0 || mon_if.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_vals: phase=%b dwell=%0d cycles=%0d, want 11/0/0",
                     mon_if.cur_phase, mon_if.dwell, mon_if.cycle_count);
        end
        checks++;
        if ({mon_if.seq_err, mon_if.illegal_code, mon_if.dwell_err, mon_if.err_sticky} !== 4'b0000 ||
            mon_if.dbg_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: flags=%b dbg=%b, want 0000/00",
                     {mon_if.seq_err, mon_if.illegal_code, mon_if.dwell_err, mon_if.err_sticky},
                     mon_if.dbg_state);
        end
    endtask

    task automatic test_legal_cycle();
        logic seen;
        seen = 1'b0;
        do_reset();
        step(R);
        checks++;
        if (mon_if.cur_phase !== R || mon_if.dwell !== 8'd1 || mon_if.dbg_state !== 2'b11) begin
            errors++;
            $display("FAIL legal_first_r: phase=%b dwell=%0d dbg=%b, want 00/1/11",
                     mon_if.cur_phase, mon_if.dwell, mon_if.dbg_state);
        end
        for (int i = 0; i < 4; i++) begin step(R); seen |= mon_if.seq_err | mon_if.illegal_code | mon_if.dwell_err; end
        checks++;
        if (mon_if.dwell !== 8'd5) begin
            errors++;
            $display("FAIL legal_r_dwell: dwell=%0d want 5", mon_if.dwell);
        end
        step(G);
        seen |= mon_if.seq_err | mon_if.illegal_code | mon_if.dwell_err;
        checks++;
        if (mon_if.cur_phase !== G || mon_if.dwell !== 8'd1 || mon_if.dbg_state !== 2'b10) begin
            errors++;
            $display("FAIL legal_r_to_g: phase=%b dwell=%0d dbg=%b, want 01/1/10",
                     mon_if.cur_phase, mon_if.dwell, mon_if.dbg_state);
        end
        for (int i = 0; i < 4; i++) begin step(G); seen |= mon_if.seq_err | mon_if.illegal_code | mon_if.dwell_err; end
        for (int i = 0; i < 2; i++) begin step(Y); seen |= mon_if.seq_err | mon_if.illegal_code | mon_if.dwell_err; end
        checks++;
        if (mon_if.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL legal_pre_count: cycles=%0d want 0", mon_if.cycle_count);
        end
        step(R);
        seen |= mon_if.seq_err | mon_if.illegal_code | mon_if.dwell_err;
        checks++;
        if (mon_if.cycle_count !== 16'd1 || mon_if.dwell !== 8'd1 || mon_if.cur_phase !== R) begin
            errors++;
            $display("FAIL legal_y_to_r: cycles=%0d dwell=%0d phase=%b, want 1/1/00",
                     mon_if.cycle_count, mon_if.dwell, mon_if.cur_phase);
        end
        checks++;
        if (seen !== 1'b0 || mon_if.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL legal_no_pulse: seen=%b sticky=%b, want 0/0", seen, mon_if.err_sticky);
        end
    endtask

    task automatic test_illegal_transition();
        do_reset();
        steps(R, 5);
        steps(G, 5);
        step(R);
        checks++;
        if (mon_if.seq_err !== 1'b1 || mon_if.err_sticky !== 1'b1 || mon_if.cur_phase !== R ||
            mon_if.cycle_count !== 16'd0 || mon_if.dwell !== 8'd1 || mon_if.dwell_err !== 1'b0) begin
            errors++;
            $display("FAIL seq_g_to_r: seq=%b sticky=%b phase=%b cycles=%0d dwell=%0d derr=%b, want 1/1/00/0/1/0",
                     mon_if.seq_err, mon_if.err_sticky, mon_if.cur_phase, mon_if.cycle_count,
                     mon_if.dwell, mon_if.dwell_err);
        end
        step(R);
        checks++;
        if (mon_if.seq_err !== 1'b0 || mon_if.err_sticky !== 1'b1 || mon_if.dwell !== 8'd2) begin
            errors++;
            $display("FAIL seq_one_cycle: seq=%b sticky=%b dwell=%0d, want 0/1/2",
                     mon_if.seq_err, mon_if.err_sticky, mon_if.dwell);
        end
    endtask

    task automatic test_illegal_code();
        do_reset();
        steps(R, 5);
        step(X);
        checks++;
        if (mon_if.illegal_code !== 1'b1 || mon_if.cur_phase !== X || mon_if.dwell !== 8'd0 ||
            mon_if.err_sticky !== 1'b1 || mon_if.dbg_state !== 2'b00) begin
            errors++;
            $display("FAIL ill_code: ill=%b phase=%b dwell=%0d sticky=%b dbg=%b, want 1/11/0/1/00",
                     mon_if.illegal_code, mon_if.cur_phase, mon_if.dwell, mon_if.err_sticky,
                     mon_if.dbg_state);
        end
        step(G);
        checks++;
        if (mon_if.illegal_code !== 1'b0 || mon_if.seq_err !== 1'b0 || mon_if.cur_phase !== G ||
            mon_if.dwell !== 8'd1) begin
            errors++;
            $display("FAIL ill_resync_g: ill=%b seq=%b phase=%b dwell=%0d, want 0/0/01/1",
                     mon_if.illegal_code, mon_if.seq_err, mon_if.cur_phase, mon_if.dwell);
        end
        // G was a partial phase, so leaving it after one cycle is not a min violation.
        step(Y);
        checks++;
        if (mon_if.dwell_err !== 1'b0 || mon_if.seq_err !== 1'b0 || mon_if.cur_phase !== Y) begin
            errors++;
            $display("FAIL ill_first_no_min: derr=%b seq=%b phase=%b, want 0/0/10",
                     mon_if.dwell_err, mon_if.seq_err, mon_if.cur_phase);
        end
    endtask

    task automatic test_max_violation();
        int pulses;
        pulses = 0;
        do_reset();
        steps(R, 5);
        for (int i = 1; i <= 12; i++) begin
            step(G);
            pulses += int'(mon_if.dwell_err);
            if (i == 9) begin
                checks++;
                if (mon_if.dwell_err !== DEN) begin
                    errors++;
                    $display("FAIL max_at_9th: derr=%b want %b", mon_if.dwell_err, DEN);
                end
            end
        end
        checks++;
        if (pulses != int'(DEN) || mon_if.dwell !== 8'd12 || mon_if.err_sticky !== DEN) begin
            errors++;
            $display("FAIL max_once: pulses=%0d dwell=%0d sticky=%b, want %0d/12/%b",
                     pulses, mon_if.dwell, mon_if.err_sticky, int'(DEN), DEN);
        end
    endtask

    task automatic test_min_violation();
        do_reset();
        steps(R, 5);
        steps(G, 5);
        step(Y);
        step(R);
        checks++;
        if (mon_if.dwell_err !== DEN || mon_if.cycle_count !== 16'd1 || mon_if.err_sticky !== DEN ||
            mon_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL min_y_short: derr=%b cycles=%0d sticky=%b seq=%b, want %b/1/%b/0",
                     mon_if.dwell_err, mon_if.cycle_count, mon_if.err_sticky, mon_if.seq_err, DEN, DEN);
        end
        mon_if.err_clr = 1'b1;
        step(R);
        mon_if.err_clr = 1'b0;
        checks++;
        if (mon_if.err_sticky !== 1'b0 || mon_if.dwell_err !== 1'b0) begin
            errors++;
            $display("FAIL min_clear: sticky=%b derr=%b, want 0/0", mon_if.err_sticky, mon_if.dwell_err);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        mon_if.err_clr = 1'b1;
        step(X);
        checks++;
        if (mon_if.illegal_code !== 1'b1 || mon_if.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ill=%b sticky=%b, want 1/1", mon_if.illegal_code, mon_if.err_sticky);
        end
        step(R);
        checks++;
        if (mon_if.err_sticky !== 1'b0 || mon_if.cur_phase !== R) begin
            errors++;
            $display("FAIL clr_after_set: sticky=%b phase=%b, want 0/00", mon_if.err_sticky, mon_if.cur_phase);
        end
        mon_if.err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq_codes [4];
        logic       seq_exp   [4];
        seq_codes = '{R, Y, G, R};
        seq_exp   = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        step(X);
        step(X);
        checks++;
        if (mon_if.illegal_code !== 1'b1 || mon_if.cur_phase !== X) begin
            errors++;
            $display("FAIL b2b_ill: ill=%b phase=%b, want 1/11", mon_if.illegal_code, mon_if.cur_phase);
        end
        for (int i = 0; i < 4; i++) begin
            step(seq_codes[i]);
            checks++;
            if (mon_if.seq_err !== seq_exp[i] || mon_if.cur_phase !== seq_codes[i] || mon_if.dwell !== 8'd1) begin
                errors++;
                $display("FAIL b2b_seq[%0d]: seq=%b phase=%b dwell=%0d, want %b/%b/1",
                         i, mon_if.seq_err, mon_if.cur_phase, mon_if.dwell, seq_exp[i], seq_codes[i]);
            end
        end
        checks++;
        if (mon_if.cycle_count !== 16'd0 || mon_if.dwell_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: cycles=%0d derr=%b, want 0/0", mon_if.cycle_count, mon_if.dwell_err);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(R);
            pulses += int'(mon_if.dwell_err);
        end
        checks++;
        if (mon_if.dwell !== 8'd255 || pulses != int'(DEN) || mon_if.cur_phase !== R) begin
            errors++;
            $display("FAIL saturate: dwell=%0d pulses=%0d phase=%b, want 255/%0d/00",
                     mon_if.dwell, pulses, mon_if.cur_phase, int'(DEN));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        steps(R, 5);
        steps(G, 3);
        mon_if.light = Y;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mon_if.cur_phase !== X || mon_if.dwell !== 8'd0 || mon_if.cycle_count !== 16'd0 ||
            {mon_if.seq_err, mon_if.illegal_code, mon_if.dwell_err, mon_if.err_sticky} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: phase=%b dwell=%0d cycles=%0d flags=%b, want 11/0/0/0000",
                     mon_if.cur_phase, mon_if.dwell, mon_if.cycle_count,
                     {mon_if.seq_err, mon_if.illegal_code, mon_if.dwell_err, mon_if.err_sticky});
        end
        @(negedge clock);
        reset = 1'b0;
        step(Y);
        checks++;
        if (mon_if.cur_phase !== Y || mon_if.seq_err !== 1'b0 || mon_if.dwell !== 8'd1) begin
            errors++;
            $display("FAIL reset_resync_y: phase=%b seq=%b dwell=%0d, want 10/0/1",
                     mon_if.cur_phase, mon_if.seq_err, mon_if.dwell);
        end
        step(R);
        checks++;
        if (mon_if.cycle_count !== 16'd1 || mon_if.dwell_err !== 1'b0 || mon_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_y: cycles=%0d derr=%b seq=%b, want 1/0/0",
                     mon_if.cycle_count, mon_if.dwell_err, mon_if.seq_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_legal_cycle();
        test_illegal_transition();
        test_illegal_code();
        test_max_violation();
        test_min_violation();
        test_set_wins();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
